// File: rtl/router_pkg.sv
// router_pkg: shared widths, state encoding and header helper for the router packet source
package router_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int LEN_W = 6;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
  typedef enum logic [2:0] {IDLE, LOAD, HDR, PAY, PAR, GAP} tx_state_e;
  function automatic logic [DATA_W-1:0] hdr_byte(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    return {len, addr};
  endfunction
endpackage

// File: rtl/router_pkt_tx_if.sv
// router_pkt_tx_if: command, payload and router-side signals of the packet source
// ROUTER_TX_PARITY_CORRUPT_EN adds cmd_bad_par
interface router_pkt_tx_if;
  import router_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_err;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [DATA_W-1:0] pl_data;
  logic pl_valid;
  logic pl_ready;
  logic busy;
  logic pkt_valid;
  logic [DATA_W-1:0] data_out;
  logic done;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
  logic cmd_bad_par;
  modport master (
    input cmd_valid, cmd_addr, cmd_len, cmd_bad_par, pl_data, pl_valid, busy,
    output cmd_ready, cmd_err, pl_ready, pkt_valid, data_out, done
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_bad_par, pl_data, pl_valid, busy,
    input cmd_ready, cmd_err, pl_ready, pkt_valid, data_out, done
  );
`else
  modport master (
    input cmd_valid, cmd_addr, cmd_len, pl_data, pl_valid, busy,
    output cmd_ready, cmd_err, pl_ready, pkt_valid, data_out, done
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, pl_data, pl_valid, busy,
    input cmd_ready, cmd_err, pl_ready, pkt_valid, data_out, done
  );
`endif
endinterface

// File: rtl/router_tx_buf.sv
// router_tx_buf: 64-byte payload store, synchronous write and asynchronous read
module router_tx_buf
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              we_i,
  input  logic [LEN_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [LEN_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**LEN_W];
  always_ff @(posedge clock)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one command's payload, then streams header, payload and parity to the router input
// ROUTER_TX_PARITY_CORRUPT_EN adds cmd_bad_par, which sends an inverted parity byte
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int IPG = 2
) (
  input logic clock,
  input logic resetn,
  router_pkt_tx_if.master bus
);
  localparam int GW = (IPG > 1) ? $clog2(IPG) : 1;
  tx_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] par_q, par_d, par_out, rdata, data_out_q, data_out_d;
  logic [GW-1:0] gap_q, gap_d;
  logic cmd_ready_q, cmd_ready_d, cmd_err_q, cmd_err_d, pl_ready_q, pl_ready_d;
  logic pkt_valid_q, pkt_valid_d, done_q, done_d, we;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
  logic bad_q, bad_d;
  assign par_out = bad_d ? ~par_d : par_d;
`else
  assign par_out = par_d;
`endif
  assign we = pl_ready_q && bus.pl_valid;
  router_tx_buf u_buf (
    .clock  (clock),
    .we_i   (we),
    .waddr_i(wr_ptr_q),
    .wdata_i(bus.pl_data),
    .raddr_i(rd_ptr_d),
    .rdata_o(rdata)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    len_d = len_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    par_d = par_q;
    gap_d = gap_q;
    cmd_err_d = 1'b0;
    done_d = 1'b0;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
    bad_d = bad_q;
`endif
    unique case (state_q)
      IDLE: if (bus.cmd_valid && cmd_ready_q) begin
        if (bus.cmd_addr == ADDR_INVALID || bus.cmd_len == '0) cmd_err_d = 1'b1;
        else begin
          state_d = LOAD;
          addr_d = bus.cmd_addr;
          len_d = bus.cmd_len;
          par_d = hdr_byte(bus.cmd_addr, bus.cmd_len);
          wr_ptr_d = '0;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
          bad_d = bus.cmd_bad_par;
`endif
        end
      end
      LOAD: if (we) begin
        wr_ptr_d = wr_ptr_q + LEN_W'(1);
        par_d = par_q ^ bus.pl_data;
        if (wr_ptr_q == len_q - LEN_W'(1)) state_d = HDR;
      end
      HDR: if (!bus.busy) begin
        state_d = PAY;
        rd_ptr_d = '0;
      end
      PAY: if (!bus.busy) begin
        rd_ptr_d = rd_ptr_q + LEN_W'(1);
        if (rd_ptr_q == len_q - LEN_W'(1)) state_d = PAR;
      end
      PAR: if (!bus.busy) begin
        done_d = 1'b1;
        gap_d = '0;
        state_d = (IPG == 0) ? IDLE : GAP;
      end
      GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(IPG - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered, so they are decoded from the state being entered
    cmd_ready_d = state_d == IDLE;
    pl_ready_d = state_d == LOAD;
    pkt_valid_d = state_d == HDR || state_d == PAY;
    data_out_d = state_d == HDR ? hdr_byte(addr_d, len_d) :
                 state_d == PAY ? rdata :
                 state_d == PAR ? par_out : '0;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      par_q <= '0;
      gap_q <= '0;
      cmd_ready_q <= 1'b1;
      cmd_err_q <= 1'b0;
      pl_ready_q <= 1'b0;
      pkt_valid_q <= 1'b0;
      data_out_q <= '0;
      done_q <= 1'b0;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
      bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      par_q <= par_d;
      gap_q <= gap_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_err_q <= cmd_err_d;
      pl_ready_q <= pl_ready_d;
      pkt_valid_q <= pkt_valid_d;
      data_out_q <= data_out_d;
      done_q <= done_d;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
      bad_q <= bad_d;
`endif
    end
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.cmd_err = cmd_err_q;
  assign bus.pl_ready = pl_ready_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.data_out = data_out_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: table, directed and random packets checked against a byte-stream model
module tb_router_pkt_tx;
  localparam int IPG = 2;
  typedef struct {
    logic [1:0] addr;
    logic [5:0] len;
    int pat;
    int bmode;
    logic err;
    logic [7:0] hdr;
  } vec_t;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [7:0] pay [64];
  logic [7:0] exp_q [$];
  logic busy_plan [128];
  bit bad_par = 1'b0;
  logic [7:0] first_hdr;
  int xfer;
  vec_t vecs [9];
  router_pkt_tx_if bif ();
  router_pkt_tx #(.IPG(IPG)) dut (.clock(clock), .resetn(resetn), .bus(bif));
  always #5 clock = ~clock;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask
  function automatic void fill_pay(input int pat);
    for (int i = 0; i < 64; i++) pay[i] = (pat == 2) ? 8'(i) : 8'($urandom);
    if (pat == 1) begin
      pay[0] = 8'hA1;
      pay[1] = 8'hB2;
      pay[2] = 8'hC3;
    end
  endfunction
  // expected router byte stream: header, payload, then XOR of everything before it
  function automatic void model(input int a, input int l);
    logic [7:0] p;
    exp_q.delete();
    exp_q.push_back(8'(l * 4 + a));
    for (int i = 0; i < l; i++) exp_q.push_back(pay[i]);
    p = '0;
    foreach (exp_q[i]) p ^= exp_q[i];
    exp_q.push_back(bad_par ? ~p : p);
  endfunction
  task automatic issue_cmd(input logic [1:0] a, input logic [5:0] l, input logic err);
    @(posedge clock); #1;
    bif.cmd_valid = 1'b1;
    bif.cmd_addr = a;
    bif.cmd_len = l;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
    bif.cmd_bad_par = bad_par;
`endif
    @(negedge clock);
    chk("cmd_ready_pre", bif.cmd_ready, 1);
    @(posedge clock); #1;
    bif.cmd_valid = 1'b0;
    @(negedge clock);
    chk("cmd_resp", {bif.cmd_err, bif.cmd_ready, bif.pl_ready, bif.pkt_valid}, {err, err, !err, 1'b0});
    if (err) begin
      @(negedge clock);
      chk("cmd_err_pulse", {bif.cmd_err, bif.cmd_ready, bif.pkt_valid}, 3'b010);
    end
  endtask
  task automatic load(input int l, input bit gaps);
    int i = 0;
    int n = 0;
    bit acc;
    @(posedge clock); #1;
    while (i < l) begin
      if (n++ > 3000) begin
        timeout("load");
        bif.pl_valid = 1'b0;
        return;
      end
      bif.pl_data = pay[i];
      bif.pl_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clock);
      acc = bif.pl_valid && bif.pl_ready;
      @(posedge clock); #1;
      if (acc) i++;
    end
    bif.pl_valid = 1'b0;
  endtask
  task automatic transmit(input int l, input int bmode, input int abort_idx);
    int idx = 0;
    int c = 0;
    logic pb = 1'b0;
    logic pv = 1'b0;
    logic [7:0] pd = '0;
    while (idx < l + 2) begin
      if (c > 3000) begin
        timeout("transmit");
        bif.busy = 1'b0;
        return;
      end
      bif.busy = bmode == 1 ? ($urandom_range(0, 2) == 0) : bmode == 2 ? (c < 128 && busy_plan[c]) : 1'b0;
      @(negedge clock);
      if (idx == abort_idx) begin
        bif.busy = 1'b0;
        return;
      end
      if (c == 0) chk("hdr_timing", {bif.pkt_valid, bif.pl_ready}, 2'b10);
      if (pb) chk($sformatf("hold%0d", idx), {bif.pkt_valid, bif.data_out}, {pv, pd});
      if (!bif.busy) begin
        chk($sformatf("byte%0d", idx), {bif.pkt_valid, bif.data_out}, {idx <= l, exp_q[idx]});
        if (idx == 0) first_hdr = bif.data_out;
        idx++;
      end
      pb = bif.busy;
      pv = bif.pkt_valid;
      pd = bif.data_out;
      c++;
      @(posedge clock); #1;
    end
    bif.busy = 1'b0;
    xfer = c;
  endtask
  task automatic gap_check();
    for (int k = 0; k <= IPG + 1; k++) begin
      @(negedge clock);
      chk($sformatf("gap%0d", k), {bif.done, bif.cmd_ready, bif.pkt_valid}, {k == 0, k >= IPG, 1'b0});
    end
  endtask
  task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic err, input int bmode, input bit gaps);
    issue_cmd(a, l, err);
    if (!err) begin
      model(int'(a), int'(l));
      load(int'(l), gaps);
      transmit(int'(l), bmode, -1);
      gap_check();
    end
  endtask
  initial begin
    logic [1:0] a;
    logic [5:0] l;
    vecs[0] = '{2'd1, 6'd3, 1, 0, 1'b0, 8'h0D};
    vecs[1] = '{2'd1, 6'd3, 1, 2, 1'b0, 8'h0D};
    vecs[2] = '{2'd3, 6'd5, 0, 0, 1'b1, 8'h00};
    vecs[3] = '{2'd1, 6'd0, 0, 0, 1'b1, 8'h00};
    vecs[4] = '{2'd2, 6'd63, 2, 0, 1'b0, 8'hFE};
    vecs[5] = '{2'd0, 6'd1, 0, 1, 1'b0, 8'h04};
    vecs[6] = '{2'd3, 6'd0, 0, 0, 1'b1, 8'h00};
    vecs[7] = '{2'd1, 6'd10, 0, 1, 1'b0, 8'h29};
    vecs[8] = '{2'd2, 6'd1, 0, 0, 1'b0, 8'h06};
    bif.cmd_valid = 1'b0;
    bif.cmd_addr = '0;
    bif.cmd_len = '0;
    bif.pl_data = '0;
    bif.pl_valid = 1'b0;
    bif.busy = 1'b0;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
    bif.cmd_bad_par = 1'b0;
`endif
    repeat (2) @(negedge clock);
    chk("reset", {bif.cmd_ready, bif.pl_ready, bif.pkt_valid, bif.done, bif.cmd_err, bif.data_out}, {5'b10000, 8'h00});
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    chk("idle", {bif.cmd_ready, bif.pl_ready, bif.pkt_valid, bif.done, bif.cmd_err, bif.data_out}, {5'b10000, 8'h00});
    for (int v = 0; v < 9; v++) begin
      fill_pay(vecs[v].pat);
      for (int i = 0; i < 128; i++) busy_plan[i] = (vecs[v].bmode == 2) && (i < 3 || i == 6 || i == 7);
      run_pkt(vecs[v].addr, vecs[v].len, vecs[v].err, vecs[v].bmode, 1'b0);
      if (!vecs[v].err) begin
        chk($sformatf("hdr_vec%0d", v), first_hdr, vecs[v].hdr);
        if (vecs[v].bmode == 0) chk($sformatf("xfer_vec%0d", v), xfer, vecs[v].len + 2);
      end
    end
    fill_pay(0);
    issue_cmd(2'd0, 6'd20, 1'b0);
    model(0, 20);
    load(20, 1'b0);
    transmit(20, 0, 11);
    resetn = 1'b0;
    #1;
    chk("async_rst", {bif.pkt_valid, bif.cmd_ready, bif.pl_ready, bif.data_out}, {3'b010, 8'h00});
    @(posedge clock); #1;
    resetn = 1'b1;
    pay[0] = 8'h5A;
    run_pkt(2'd0, 6'd1, 1'b0, 0, 1'b0);
    chk("hdr_after_rst", first_hdr, 8'h04);
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
    bad_par = 1'b1;
    fill_pay(1);
    run_pkt(2'd1, 6'd3, 1'b0, 0, 1'b0);
    bad_par = 1'b0;
`endif
    for (int r = 0; r < 25; r++) begin
      a = 2'($urandom_range(0, 3));
      l = (r % 4 == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 8));
      fill_pay(0);
      run_pkt(a, l, a == 2'd3 || l == 6'd0, 1, 1'b1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
